ex_result_stage: RTL and testbench
==================================

# ex_result_stage

Registered receiving end of the ALU: captures `result`, `adder_out`, `cmp_out` and `zero` from the execute-stage ALU together with instruction metadata. It resolves conditional branches and jumps, emits a one-cycle PC redirect, and forwards writeback data downstream. A two-entry skid buffer with valid/ready handshakes on both sides decouples the ALU from writeback stalls while sustaining one instruction per cycle.

## Interface
Parameters:
- XLEN, 32, datapath width.

Ports (`rst` is synchronous, active-high; single clock `clk`):
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- flush  input  1  kill all buffered entries and block acceptance this cycle
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept; equals NOT skid_valid
- in_result  input  XLEN  ALU `result`
- in_adder_out  input  XLEN  ALU `adder_out`; jump target for JAL/JALR
- in_cmp_out  input  1  ALU `cmp_out`; less-than, signed or unsigned per ALUOp
- in_zero  input  1  ALU `zero`; operands equal
- in_pc  input  XLEN  instruction PC
- in_ilen2  input  1  1 = compressed (16-bit) instruction
- in_br_target  input  XLEN  precomputed PC+imm for conditional branches
- in_br_type  input  3  0 none, 1 BEQ, 2 BNE, 3 BLT/BLTU, 4 BGE/BGEU, 5 JAL, 6 JALR, 7 reserved (treated as none)
- in_rd  input  5  destination register
- in_reg_write  input  1  destination write enable
- out_valid  output  1  downstream entry valid
- out_ready  input  1  downstream accepts
- out_wb_data  output  XLEN  writeback value
- out_rd  output  5  destination register
- out_reg_write  output  1  write enable; forced 0 when out_rd = 0
- redirect_valid  output  1  one-cycle pulse: fetch must restart
- redirect_pc  output  XLEN  restart address

## Operation
- Accept: `in_valid & in_ready & ~flush & ~rst`.
- Taken logic at accept:
  - BEQ: `zero`; BNE: `~zero`.
  - BLT: `cmp_out`; BGE: `~cmp_out`.
  - JAL/JALR: 1; none/reserved: 0.
- Target:
  - Conditional branches: in_br_target.
  - JAL: in_adder_out.
  - JALR: in_adder_out with bit 0 cleared.
  - Bit 0 is always 0 on redirect_pc.
- Writeback data:
  - JAL/JALR: in_pc + 2 if in_ilen2, else in_pc + 4 (mod 2^XLEN).
  - Otherwise: in_result.
- Conditional branches force reg_write = 0 but still produce an output entry (retire slot).
- Buffer: main entry (drives out_*) and skid entry.
  - Accept with main empty or draining: load main.
  - Accept while main is held (out_valid & ~out_ready): load skid.
  - Main drains with skid full: skid moves to main; skid clears.
  - in_ready = ~skid_valid; never accept into a full skid.
- Redirect: registered; redirect_valid = 1 in the cycle after an accept with taken = 1, carrying that entry's target. It is independent of downstream stalls.
- Flush: clears main and skid valid. It suppresses acceptance in the same cycle and suppresses any redirect pending for the next cycle. Upstream handles the killed instructions.

## Timing
- Reset values: out_valid 0, redirect_valid 0, out_wb_data 0, out_rd 0, out_reg_write 0, redirect_pc 0. in_ready reads 1 once skid_valid is cleared; accepts are ignored while rst = 1.
- Latency: accept in cycle N gives out_valid in cycle N+1 (main empty) and redirect_valid in cycle N+1.
- Throughput: 1 per cycle with out_ready held 1. With out_ready low, two entries are buffered, then in_ready drops in the cycle after the second accept.
- Downstream: out_* hold stable while out_valid & ~out_ready.
- Simultaneous accept and drain with main full and skid empty: main loads new entry; no skid use.
- Simultaneous accept and flush: flush wins; nothing is accepted.
- Reset mid-operation: both entries and any pending redirect are dropped in the same cycle.
- Back-to-back taken branches: each produces its own pulse in consecutive cycles. Upstream guarantees the wrong-path entry is flushed.

## Test plan
- Reset/idle: assert rst for 2 cycles with in_valid = 1 -> no accepts; out_valid = 0, redirect_valid = 0; in_ready = 1 after release.
- Streaming ALU ops: 8 consecutive ops, result = 0x10+i, rd = i+1, out_ready = 1 -> out_wb_data 0x10..0x17 in order, one cycle after each accept.
- Branch resolution:
  - BEQ with zero = 1, br_target 0x200 -> redirect_valid pulse with redirect_pc 0x200; reg_write 0.
  - BNE with zero = 1 -> no pulse.
  - BGE with cmp_out = 0 -> pulse.
- Jumps:
  - JALR at pc 0x100, ilen2 = 0, adder_out 0x2003, rd = 1 -> redirect_pc 0x2002, out_wb_data 0x104.
  - Compressed JAL at pc 0x100, ilen2 = 1 -> out_wb_data 0x102.
- Backpressure: out_ready = 0 with 3 offered entries A, B, C -> A and B accepted; in_ready = 0 from the cycle after B; C is held. Releasing out_ready delivers A, B, C in order with no loss or duplicate.
- Flush/x0:
  - flush with both entries full and a taken branch accepted the prior cycle -> out_valid = 0 and no redirect pulse next cycle.
  - Op with rd = 0, reg_write = 1 -> out_reg_write = 0.

Source files
------------

// File: rtl/ex_result_stage_if.sv
// ex_result_stage_if: upstream ALU handshake, downstream writeback handshake
// and PC redirect signals of the execute result stage.
interface ex_result_stage_if #(
    parameter int unsigned XLEN = 32
);
    // Pipeline control
    logic            flush;

    // Upstream (ALU side)
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_result;
    logic [XLEN-1:0] in_adder_out;
    logic            in_cmp_out;
    logic            in_zero;
    logic [XLEN-1:0] in_pc;
    logic            in_ilen2;
    logic [XLEN-1:0] in_br_target;
    logic [2:0]      in_br_type;
    logic [4:0]      in_rd;
    logic            in_reg_write;

    // Downstream (writeback side)
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_wb_data;
    logic [4:0]      out_rd;
    logic            out_reg_write;

    // Fetch redirect
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    // Stage side
    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_result,
        input  in_adder_out,
        input  in_cmp_out,
        input  in_zero,
        input  in_pc,
        input  in_ilen2,
        input  in_br_target,
        input  in_br_type,
        input  in_rd,
        input  in_reg_write,
        output out_valid,
        input  out_ready,
        output out_wb_data,
        output out_rd,
        output out_reg_write,
        output redirect_valid,
        output redirect_pc
    );

    // Surrounding pipeline side
    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_result,
        output in_adder_out,
        output in_cmp_out,
        output in_zero,
        output in_pc,
        output in_ilen2,
        output in_br_target,
        output in_br_type,
        output in_rd,
        output in_reg_write,
        input  out_valid,
        output out_ready,
        input  out_wb_data,
        input  out_rd,
        input  out_reg_write,
        input  redirect_valid,
        input  redirect_pc
    );
endinterface

// File: rtl/ex_result_stage.sv
// ex_result_stage: registers ALU results, resolves branches/jumps into a
// one-cycle redirect pulse and buffers writeback entries in a two-entry skid
// buffer so the ALU is decoupled from writeback stalls at full throughput.
module ex_result_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    ex_result_stage_if.slave  bus
);

    localparam int unsigned RD_W = 5;

    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_JAL  = 3'd5;
    localparam logic [2:0] BR_JALR = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] wb_data;
        logic [RD_W-1:0] rd;
        logic            reg_write;
    } entry_t;

    // Buffer occupancy: main drives out_*, skid catches one entry under stall
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_BOTH  = 2'd2
    } state_e;

    state_e          state_q;
    state_e          state_d;
    entry_t          main_q;
    entry_t          skid_q;
    entry_t          in_entry_c;
    logic            taken_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] link_c;
    logic            accept_c;
    logic            drain_c;
    logic            in_ready_c;
    logic            main_valid_c;
    logic            load_main_c;
    logic            load_skid_c;
    logic            move_skid_c;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;

    assign in_ready_c   = (state_q != ST_BOTH);
    assign main_valid_c = (state_q != ST_EMPTY);
    assign accept_c     = bus.in_valid & in_ready_c & ~bus.flush & ~rst;
    assign drain_c      = main_valid_c & bus.out_ready;
    assign link_c       = bus.in_pc + (bus.in_ilen2 ? XLEN'(2) : XLEN'(4));

    // Branch resolution and writeback entry formation for the incoming op
    always_comb begin
        taken_c              = 1'b0;
        target_c             = {bus.in_br_target[XLEN-1:1], 1'b0};
        in_entry_c.wb_data   = bus.in_result;
        in_entry_c.rd        = bus.in_rd;
        in_entry_c.reg_write = bus.in_reg_write;
        case (bus.in_br_type)
            BR_BEQ: begin
                taken_c              = bus.in_zero;
                in_entry_c.reg_write = 1'b0;
            end
            BR_BNE: begin
                taken_c              = ~bus.in_zero;
                in_entry_c.reg_write = 1'b0;
            end
            BR_BLT: begin
                taken_c              = bus.in_cmp_out;
                in_entry_c.reg_write = 1'b0;
            end
            BR_BGE: begin
                taken_c              = ~bus.in_cmp_out;
                in_entry_c.reg_write = 1'b0;
            end
            BR_JAL, BR_JALR: begin
                taken_c            = 1'b1;
                target_c           = {bus.in_adder_out[XLEN-1:1], 1'b0};
                in_entry_c.wb_data = link_c;
            end
            default: begin
            end
        endcase
        // x0 is never written
        if (bus.in_rd == RD_W'(0)) begin
            in_entry_c.reg_write = 1'b0;
        end
    end

    // Occupancy next-state and buffer load controls
    always_comb begin
        state_d     = state_q;
        load_main_c = 1'b0;
        load_skid_c = 1'b0;
        move_skid_c = 1'b0;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        load_main_c = 1'b1;
                        state_d     = ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (accept_c && drain_c) begin
                        load_main_c = 1'b1;
                    end else if (accept_c) begin
                        load_skid_c = 1'b1;
                        state_d     = ST_BOTH;
                    end else if (drain_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_BOTH: begin
                    if (drain_c) begin
                        move_skid_c = 1'b1;
                        state_d     = ST_MAIN;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main and skid entry payload registers
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_c) begin
                main_q <= in_entry_c;
            end else if (move_skid_c) begin
                main_q <= skid_q;
            end
            if (load_skid_c) begin
                skid_q <= in_entry_c;
            end
        end
    end

    // Redirect pulse, independent of downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= accept_c & taken_c;
            if (accept_c && taken_c) begin
                redirect_pc_q <= target_c;
            end
        end
    end

    assign bus.in_ready       = in_ready_c;
    assign bus.out_valid      = main_valid_c;
    assign bus.out_wb_data    = main_q.wb_data;
    assign bus.out_rd         = main_q.rd;
    assign bus.out_reg_write  = main_q.reg_write;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage: scoreboard bench for ex_result_stage; the driver pushes
// reference-model expectations on accept, a negedge monitor pops and compares.
module tb_ex_result_stage;

    localparam int unsigned XLEN = 32;

    typedef struct {
        logic [2:0]  br;
        logic        zero;
        logic        cmp;
        logic        ilen2;
        logic        rw;
        logic [31:0] pc;
        logic [31:0] adder;
        logic [31:0] tgt;
        logic [31:0] result;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rw;
        int          acc;
    } out_exp_t;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    out_exp_t oq[$];
    rd_exp_t  rq[$];
    out_exp_t mon_e;
    rd_exp_t  mon_r;

    ex_result_stage_if #(.XLEN(XLEN)) bus ();

    ex_result_stage #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference behaviour of one instruction, straight from the ISA rules
    function automatic void model(input op_t o, output bit taken,
                                  output logic [31:0] tgt, output out_exp_t e);
        bit is_branch;
        taken     = 1'b0;
        is_branch = 1'b0;
        tgt       = o.tgt & 32'hFFFF_FFFE;
        e.wb      = o.result;
        e.rd      = o.rd;
        e.rw      = o.rw;
        e.acc     = 0;
        if (o.br == 3'd1) begin is_branch = 1'b1; taken = o.zero;  end
        if (o.br == 3'd2) begin is_branch = 1'b1; taken = !o.zero; end
        if (o.br == 3'd3) begin is_branch = 1'b1; taken = o.cmp;   end
        if (o.br == 3'd4) begin is_branch = 1'b1; taken = !o.cmp;  end
        if (o.br == 3'd5 || o.br == 3'd6) begin
            taken = 1'b1;
            tgt   = o.adder & 32'hFFFF_FFFE;
            e.wb  = o.pc + (o.ilen2 ? 32'd2 : 32'd4);
        end
        if (is_branch || o.rd == 5'd0) e.rw = 1'b0;
    endfunction

    function automatic op_t mk(input logic [2:0] br, input logic [31:0] result,
                               input logic [4:0] rd, input logic rw);
        op_t o;
        o.br = br; o.zero = 1'b0; o.cmp = 1'b0; o.ilen2 = 1'b0; o.rw = rw;
        o.pc = 32'h100; o.adder = 32'h0; o.tgt = 32'h0; o.result = result; o.rd = rd;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.br     = 3'($urandom_range(0, 7));
        o.zero   = 1'($urandom_range(0, 1));
        o.cmp    = 1'($urandom_range(0, 1));
        o.ilen2  = 1'($urandom_range(0, 1));
        o.rw     = 1'($urandom_range(0, 1));
        o.pc     = $urandom;
        o.adder  = $urandom;
        o.tgt    = $urandom;
        o.result = $urandom;
        o.rd     = 5'($urandom_range(0, 31));
        return o;
    endfunction

    // One cycle of stimulus; expectations are queued for any accepted op
    task automatic step(input bit v, input op_t o, input bit ordy, input bit fl, output bit acc);
        bit          taken;
        logic [31:0] tgt;
        out_exp_t    e;
        @(posedge clk);
        #1;
        bus.in_valid     = v;
        bus.in_result    = o.result;
        bus.in_adder_out = o.adder;
        bus.in_cmp_out   = o.cmp;
        bus.in_zero      = o.zero;
        bus.in_pc        = o.pc;
        bus.in_ilen2     = o.ilen2;
        bus.in_br_target = o.tgt;
        bus.in_br_type   = o.br;
        bus.in_rd        = o.rd;
        bus.in_reg_write = o.rw;
        bus.flush        = fl;
        bus.out_ready    = fl ? 1'b0 : ordy;
        chk("in_ready", bus.in_ready, oq.size() < 2);
        chk("out_valid", bus.out_valid, oq.size() > 0);
        acc = v && bus.in_ready && !fl && !rst;
        if (fl) oq.delete();
        if (acc) begin
            model(o, taken, tgt, e);
            e.acc = cyc;
            oq.push_back(e);
            if (taken) rq.push_back('{tgt, cyc + 1});
        end
    endtask

    // Monitor: compares delivered entries and redirect pulses with the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.out_valid && bus.out_ready) begin
                if (oq.size() == 0) begin
                    fail_now("out_unexpected", 64'(bus.out_wb_data), 64'h0);
                end else begin
                    mon_e = oq.pop_front();
                    chk("out_wb_data", bus.out_wb_data, mon_e.wb);
                    chk("out_rd", bus.out_rd, mon_e.rd);
                    chk("out_reg_write", bus.out_reg_write, mon_e.rw);
                    chk("out_latency", cyc > mon_e.acc, 1'b1);
                end
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                mon_r = rq.pop_front();
                fail_now("redirect_missing", 64'h0, 64'(mon_r.pc));
            end
            if (bus.redirect_valid) begin
                if (rq.size() > 0 && rq[0].cyc == cyc) begin
                    mon_r = rq.pop_front();
                    chk("redirect_pc", bus.redirect_pc, mon_r.pc);
                end else begin
                    fail_now("redirect_unexpected", 64'(bus.redirect_pc), 64'h0);
                end
            end else if (rq.size() > 0 && rq[0].cyc == cyc) begin
                mon_r = rq.pop_front();
                fail_now("redirect_missing", 64'h0, 64'(mon_r.pc));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit  acc;
        op_t o;
        op_t a;
        op_t b;
        op_t c;

        // Reset with a taken jump offered throughout
        rst = 1'b1;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_br_type = 3'd5; bus.in_adder_out = 32'h40;
        bus.in_result = '0; bus.in_cmp_out = 1'b0; bus.in_zero = 1'b0;
        bus.in_pc = 32'h100; bus.in_ilen2 = 1'b0; bus.in_br_target = '0;
        bus.in_rd = 5'd1; bus.in_reg_write = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_redirect_valid", bus.redirect_valid, 1'b0);
        chk("rst_out_wb_data", bus.out_wb_data, 32'h0);
        chk("rst_out_rd", bus.out_rd, 5'h0);
        chk("rst_out_reg_write", bus.out_reg_write, 1'b0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        chk("rst2_out_valid", bus.out_valid, 1'b0);
        chk("rst2_redirect_valid", bus.redirect_valid, 1'b0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        mon_en = 1'b1;

        // Streaming ALU ops at full rate
        for (int i = 0; i < 8; i++) begin
            step(1'b1, mk(3'd0, 32'h10 + 32'(i), 5'(i + 1), 1'b1), 1'b1, 1'b0, acc);
            chk("stream_accept", acc, 1'b1);
        end
        step(1'b0, mk(3'd0, 0, 0, 0), 1'b1, 1'b0, acc);

        // Branches and jumps
        o = mk(3'd1, 32'h55, 5'd3, 1'b1); o.zero = 1'b1; o.tgt = 32'h200;
        step(1'b1, o, 1'b1, 1'b0, acc);
        o = mk(3'd2, 32'h56, 5'd3, 1'b1); o.zero = 1'b1; o.tgt = 32'h300;
        step(1'b1, o, 1'b1, 1'b0, acc);
        o = mk(3'd4, 32'h57, 5'd3, 1'b1); o.cmp = 1'b0; o.tgt = 32'h344;
        step(1'b1, o, 1'b1, 1'b0, acc);
        o = mk(3'd3, 32'h58, 5'd3, 1'b1); o.cmp = 1'b1; o.tgt = 32'h481;
        step(1'b1, o, 1'b1, 1'b0, acc);
        o = mk(3'd6, 32'h59, 5'd1, 1'b1); o.adder = 32'h2003;
        step(1'b1, o, 1'b1, 1'b0, acc);
        o = mk(3'd5, 32'h5a, 5'd1, 1'b1); o.ilen2 = 1'b1; o.adder = 32'h400;
        step(1'b1, o, 1'b1, 1'b0, acc);
        step(1'b1, mk(3'd0, 32'h5b, 5'd0, 1'b1), 1'b1, 1'b0, acc);
        step(1'b1, mk(3'd7, 32'h5c, 5'd9, 1'b1), 1'b1, 1'b0, acc);
        step(1'b0, mk(3'd0, 0, 0, 0), 1'b1, 1'b0, acc);

        // Backpressure: A and B buffered, C held until downstream drains
        a = mk(3'd0, 32'hA, 5'd10, 1'b1);
        b = mk(3'd0, 32'hB, 5'd11, 1'b1);
        c = mk(3'd0, 32'hC, 5'd12, 1'b1);
        step(1'b1, a, 1'b0, 1'b0, acc); chk("bp_accept_a", acc, 1'b1);
        step(1'b1, b, 1'b0, 1'b0, acc); chk("bp_accept_b", acc, 1'b1);
        step(1'b1, c, 1'b0, 1'b0, acc); chk("bp_hold_c", acc, 1'b0);
        step(1'b1, c, 1'b0, 1'b0, acc); chk("bp_hold_c2", acc, 1'b0);
        acc = 1'b0;
        for (int i = 0; i < 5 && !acc; i++) step(1'b1, c, 1'b1, 1'b0, acc);
        chk("bp_accept_c", acc, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, c, 1'b1, 1'b0, acc);

        // Flush with both entries full and a taken branch just accepted
        step(1'b1, mk(3'd0, 32'hD, 5'd13, 1'b1), 1'b0, 1'b0, acc);
        o = mk(3'd1, 32'hE, 5'd14, 1'b1); o.zero = 1'b1; o.tgt = 32'h280;
        step(1'b1, o, 1'b0, 1'b0, acc); chk("fl_accept_br", acc, 1'b1);
        o = mk(3'd5, 32'hF, 5'd15, 1'b1); o.adder = 32'h900;
        step(1'b1, o, 1'b0, 1'b1, acc);
        step(1'b0, o, 1'b1, 1'b0, acc);
        // Flush on an idle stage with a jump offered: flush wins
        step(1'b1, o, 1'b1, 1'b1, acc); chk("fl_blocks_accept", acc, 1'b0);
        step(1'b0, o, 1'b1, 1'b0, acc);
        step(1'b0, o, 1'b1, 1'b0, acc);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rand_op(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0, acc);
        end

        // Drain
        for (int i = 0; i < 10 && (oq.size() > 0 || rq.size() > 0); i++) begin
            step(1'b0, mk(3'd0, 0, 0, 0), 1'b1, 1'b0, acc);
        end
        step(1'b0, mk(3'd0, 0, 0, 0), 1'b1, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        chk("drain_out_queue", 64'(oq.size()), 64'h0);
        chk("drain_redirect_queue", 64'(rq.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
